// File: rtl/threshold_stage.sv
// Two-stage RGB pixel-pair binariser with output-side frame bookkeeping
// (position, white-pixel count, frame completion and malformed-frame flag).
module threshold_stage #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int THRESHOLD    = 90,
  parameter int INVERT       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic [7:0]  red_even_in,
  input  logic [7:0]  green_even_in,
  input  logic [7:0]  blue_even_in,
  input  logic [7:0]  red_odd_in,
  input  logic [7:0]  green_odd_in,
  input  logic [7:0]  blue_odd_in,
  output logic [7:0]  red_even_out,
  output logic [7:0]  green_even_out,
  output logic [7:0]  blue_even_out,
  output logic [7:0]  red_odd_out,
  output logic [7:0]  green_odd_out,
  output logic [7:0]  blue_odd_out,
  output logic        out_valid,
  output logic        vsync_out,
  output logic        frame_done,
  output logic [18:0] white_count,
  output logic [9:0]  row_out,
  output logic [10:0] col_out,
  output logic        frame_error
);

  localparam int unsigned PAIRS = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int unsigned CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);
  localparam logic [9:0]  THRESH3    = 10'(3 * THRESHOLD);
  localparam logic [10:0] LAST_COL   = 11'(IMAGE_WIDTH - 2);
  localparam logic        INVERT_BIT = (INVERT != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [9:0]       sum_even_d, sum_even_q, sum_odd_d, sum_odd_q;
  logic             valid1_q, vsync1_q, vsync2_q;
  logic             pix_even_d, pix_even_q, pix_odd_d, pix_odd_q;
  logic             out_valid_q;
  logic             white_even, white_odd, vsync_rise;
  logic [1:0]       n_white;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [9:0]       row_d, row_q, row_out_d, row_out_q;
  logic [10:0]      col_d, col_q, col_out_d, col_out_q;
  logic [18:0]      white_d, white_q;
  logic             done_d, done_q, err_d, err_q;

  always_comb begin
    sum_even_d = {2'b00, red_even_in} + {2'b00, green_even_in} + {2'b00, blue_even_in};
    sum_odd_d  = {2'b00, red_odd_in}  + {2'b00, green_odd_in}  + {2'b00, blue_odd_in};
    white_even = (sum_even_q > THRESH3) ^ INVERT_BIT;
    white_odd  = (sum_odd_q  > THRESH3) ^ INVERT_BIT;
    pix_even_d = valid1_q ? white_even : pix_even_q;
    pix_odd_d  = valid1_q ? white_odd  : pix_odd_q;
    n_white    = {1'b0, white_even} + {1'b0, white_odd};
  end

  // The rise is taken between vsync stage 1 and stage 2 so the clear lands in
  // the same cycle vsync_out rises, ahead of any pair sharing that input cycle.
  assign vsync_rise = vsync1_q & ~vsync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    white_d   = white_q;
    err_d     = err_q;
    done_d    = 1'b0;
    row_out_d = row_out_q;
    col_out_d = col_out_q;
    if (vsync_rise) begin
      if (state_q == ACTIVE && cnt_q != '0) err_d = 1'b1;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      white_d = '0;
      state_d = ACTIVE;
    end
    if (valid1_q) begin
      if (state_d == ACTIVE) begin
        row_out_d = row_d;
        col_out_d = col_d;
        white_d   = white_d + {17'd0, n_white};
        if (col_d == LAST_COL) begin
          col_d = '0;
          row_d = row_d + 10'd1;
        end else begin
          col_d = col_d + 11'd2;
        end
        if (cnt_d == LAST_PAIR) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
        cnt_d = cnt_d + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_even_q  <= '0;
      sum_odd_q   <= '0;
      valid1_q    <= 1'b0;
      vsync1_q    <= 1'b0;
      vsync2_q    <= 1'b0;
      pix_even_q  <= 1'b0;
      pix_odd_q   <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      white_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      row_out_q   <= '0;
      col_out_q   <= '0;
    end else begin
      sum_even_q  <= sum_even_d;
      sum_odd_q   <= sum_odd_d;
      valid1_q    <= hsync_in;
      vsync1_q    <= vsync_in;
      vsync2_q    <= vsync1_q;
      pix_even_q  <= pix_even_d;
      pix_odd_q   <= pix_odd_d;
      out_valid_q <= valid1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      white_q     <= white_d;
      err_q       <= err_d;
      done_q      <= done_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
    end
  end

  assign red_even_out   = {8{pix_even_q}};
  assign green_even_out = {8{pix_even_q}};
  assign blue_even_out  = {8{pix_even_q}};
  assign red_odd_out    = {8{pix_odd_q}};
  assign green_odd_out  = {8{pix_odd_q}};
  assign blue_odd_out   = {8{pix_odd_q}};
  assign out_valid      = out_valid_q;
  assign vsync_out      = vsync2_q;
  assign frame_done     = done_q;
  assign white_count    = white_q;
  assign row_out        = row_out_q;
  assign col_out        = col_out_q;
  assign frame_error    = err_q;

endmodule

// File: tb/tb_threshold_stage.sv
// Bench for threshold_stage: three instances (4x2, 4x2 inverted, 768x16) share
// one input stream; a frame-level reference model plus table and directed checks.
module tb_threshold_stage;

  typedef struct packed {
    logic       vs, hv;
    logic [7:0] r0, g0, b0, r1, g1, b1;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ev, od;
    logic        vso, done;
    logic [18:0] wc;
    logic [9:0]  row;
    logic [10:0] col;
    logic        err;
  } rec_t;

  typedef struct {
    int         idx, st, white, row, col;
    bit         err, pvs;
    logic [7:0] ev, od;
  } ms_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic       w_norm, w_inv;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic vsync_in = 1'b0, hsync_in = 1'b0;
  logic [7:0] rei = '0, gei = '0, bei = '0, roi = '0, goi = '0, boi = '0;

  logic [7:0]  reo[3], geo[3], beo[3], roo[3], goo[3], boo[3];
  logic        ov[3], vso[3], fd[3], fe[3];
  logic [18:0] wc[3];
  logic [9:0]  ro[3];
  logic [10:0] co[3];

  int tests = 0, fails = 0;
  int dc[3];
  ms_t ms[3];
  rec_t pend[3];

  always #5 clk = ~clk;

  threshold_stage #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .THRESHOLD(90), .INVERT(0)) u_small (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .red_even_in(rei), .green_even_in(gei), .blue_even_in(bei),
    .red_odd_in(roi), .green_odd_in(goi), .blue_odd_in(boi),
    .red_even_out(reo[0]), .green_even_out(geo[0]), .blue_even_out(beo[0]),
    .red_odd_out(roo[0]), .green_odd_out(goo[0]), .blue_odd_out(boo[0]),
    .out_valid(ov[0]), .vsync_out(vso[0]), .frame_done(fd[0]), .white_count(wc[0]),
    .row_out(ro[0]), .col_out(co[0]), .frame_error(fe[0]));

  threshold_stage #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .THRESHOLD(90), .INVERT(1)) u_inv (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .red_even_in(rei), .green_even_in(gei), .blue_even_in(bei),
    .red_odd_in(roi), .green_odd_in(goi), .blue_odd_in(boi),
    .red_even_out(reo[1]), .green_even_out(geo[1]), .blue_even_out(beo[1]),
    .red_odd_out(roo[1]), .green_odd_out(goo[1]), .blue_odd_out(boo[1]),
    .out_valid(ov[1]), .vsync_out(vso[1]), .frame_done(fd[1]), .white_count(wc[1]),
    .row_out(ro[1]), .col_out(co[1]), .frame_error(fe[1]));

  threshold_stage #(.IMAGE_WIDTH(768), .IMAGE_HEIGHT(16), .THRESHOLD(90), .INVERT(0)) u_big (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .red_even_in(rei), .green_even_in(gei), .blue_even_in(bei),
    .red_odd_in(roi), .green_odd_in(goi), .blue_odd_in(boi),
    .red_even_out(reo[2]), .green_even_out(geo[2]), .blue_even_out(beo[2]),
    .red_odd_out(roo[2]), .green_odd_out(goo[2]), .blue_odd_out(boo[2]),
    .out_valid(ov[2]), .vsync_out(vso[2]), .frame_done(fd[2]), .white_count(wc[2]),
    .row_out(ro[2]), .col_out(co[2]), .frame_error(fe[2]));

  function automatic int pw(int i);   return (i == 2) ? 768 : 4; endfunction
  function automatic int ph(int i);   return (i == 2) ? 16 : 2;  endfunction
  function automatic bit pinv(int i); return (i == 1);           endfunction

  function automatic in_t mk(logic vs, logic hv, logic [7:0] r0, logic [7:0] g0, logic [7:0] b0,
                             logic [7:0] r1, logic [7:0] g1, logic [7:0] b1);
    in_t x;
    x.vs = vs; x.hv = hv;
    x.r0 = r0; x.g0 = g0; x.b0 = b0; x.r1 = r1; x.g1 = g1; x.b1 = b1;
    return x;
  endfunction

  // Reference: brightness rule per pixel, frame position from the pair index.
  task automatic model_step(input int i, input in_t x, output rec_t r);
    bit rise, we, wo;
    int s0, s1;
    rise = x.vs && !ms[i].pvs;
    ms[i].pvs = x.vs;
    r = '0;
    if (rise) begin
      if (ms[i].st == 1 && ms[i].idx != 0) ms[i].err = 1'b1;
      ms[i].idx = 0; ms[i].white = 0; ms[i].st = 1;
    end
    if (x.hv) begin
      s0 = int'(x.r0) + int'(x.g0) + int'(x.b0);
      s1 = int'(x.r1) + int'(x.g1) + int'(x.b1);
      we = (s0 > 3 * 90) != pinv(i);
      wo = (s1 > 3 * 90) != pinv(i);
      ms[i].ev = we ? 8'hFF : 8'h00;
      ms[i].od = wo ? 8'hFF : 8'h00;
      if (ms[i].st == 1) begin
        ms[i].row = (2 * ms[i].idx) / pw(i);
        ms[i].col = (2 * ms[i].idx) % pw(i);
        ms[i].white += int'(we) + int'(wo);
        if (ms[i].idx == pw(i) * ph(i) / 2 - 1) begin
          r.done = 1'b1;
          ms[i].st = 2;
        end
        ms[i].idx++;
      end else begin
        ms[i].err = 1'b1;
      end
    end
    r.valid = x.hv;
    r.ev    = ms[i].ev;
    r.od    = ms[i].od;
    r.vso   = x.vs;
    r.wc    = 19'(ms[i].white);
    r.row   = 10'(ms[i].row);
    r.col   = 11'(ms[i].col);
    r.err   = ms[i].err;
  endtask

  task automatic cmp_rec(input int i, input rec_t e, input string nm);
    rec_t a;
    bit ok;
    a.valid = ov[i]; a.ev = reo[i]; a.od = roo[i]; a.vso = vso[i]; a.done = fd[i];
    a.wc = wc[i]; a.row = ro[i]; a.col = co[i]; a.err = fe[i];
    ok = (a == e) && geo[i] == e.ev && beo[i] == e.ev && goo[i] == e.od && boo[i] == e.od;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s dut%0d got v=%b e=%h/%h/%h o=%h/%h/%h vs=%b d=%b wc=%0d r=%0d c=%0d err=%b want v=%b e=%h o=%h vs=%b d=%b wc=%0d r=%0d c=%0d err=%b",
               nm, i, a.valid, a.ev, geo[i], beo[i], a.od, goo[i], boo[i], a.vso, a.done, a.wc,
               a.row, a.col, a.err, e.valid, e.ev, e.od, e.vso, e.done, e.wc, e.row, e.col, e.err);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input in_t x);
    rec_t nr[3];
    vsync_in = x.vs; hsync_in = x.hv;
    rei = x.r0; gei = x.g0; bei = x.b0; roi = x.r1; goi = x.g1; boi = x.b1;
    for (int i = 0; i < 3; i++) model_step(i, x, nr[i]);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmp_rec(i, pend[i], "stream");
      pend[i] = nr[i];
      if (fd[i]) dc[i]++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(mk(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    vsync_in = 1'b0; hsync_in = 1'b0;
    rei = '0; gei = '0; bei = '0; roi = '0; goi = '0; boi = '0;
    #1;
    for (int i = 0; i < 3; i++) cmp_rec(i, '0, "reset_zero");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ms[i].idx = 0; ms[i].st = 0; ms[i].white = 0; ms[i].row = 0; ms[i].col = 0;
      ms[i].err = 1'b0; ms[i].pvs = 1'b0; ms[i].ev = '0; ms[i].od = '0;
      pend[i] = '0;
      dc[i] = 0;
    end
  endtask

  task automatic frame4(input logic [7:0] e, input logic [7:0] o);
    step(mk(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    for (int k = 0; k < 4; k++) step(mk(1'b0, 1'b1, e, e, e, o, o, o));
  endtask

  vec_t vt[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd90,  8'd90,  8'd90,  1'b0, 1'b1};
    vt[1] = '{8'd91,  8'd90,  8'd90,  1'b1, 1'b0};
    vt[2] = '{8'd90,  8'd91,  8'd89,  1'b0, 1'b1};
    vt[3] = '{8'd100, 8'd100, 8'd71,  1'b1, 1'b0};
    vt[4] = '{8'd255, 8'd255, 8'd255, 1'b1, 1'b0};
    vt[5] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b1};

    #2;
    reset_dut();
    idle(2);

    // Basic frame: bright even, dark odd.
    frame4(8'd100, 8'd80);
    idle(1);
    chk("seq1_row_last", int'(ro[0]), 1);
    chk("seq1_col_last", int'(co[0]), 2);
    chk("seq1_done_last", int'(fd[0]), 1);
    chk("seq1_even", int'(reo[0]), 255);
    chk("seq1_odd", int'(roo[0]), 0);
    idle(1);
    chk("seq1_white", int'(wc[0]), 4);
    chk("seq1_done_cnt", dc[0], 1);
    chk("seq1_no_err", int'(fe[0]), 0);

    // Extra pair after frame_done.
    step(mk(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255));
    idle(1);
    chk("extra_even", int'(reo[0]), 255);
    chk("extra_odd", int'(roo[0]), 255);
    chk("extra_valid", int'(ov[0]), 1);
    chk("extra_white", int'(wc[0]), 4);
    chk("extra_err", int'(fe[0]), 1);

    // Threshold boundary, normal and inverted instances.
    for (int v = 0; v < 6; v++) begin
      step(mk(1'b0, 1'b1, vt[v].r, vt[v].g, vt[v].b, vt[v].r, vt[v].g, vt[v].b));
      idle(1);
      chk($sformatf("bound%0d_norm", v), int'(reo[0]), vt[v].w_norm ? 255 : 0);
      chk($sformatf("bound%0d_inv", v), int'(roo[1]), vt[v].w_inv ? 255 : 0);
    end

    // Short frame, then a complete one.
    reset_dut();
    step(mk(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    for (int k = 0; k < 2; k++) step(mk(1'b0, 1'b1, 8'd200, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0));
    frame4(8'd200, 8'd0);
    idle(2);
    chk("short_err", int'(fe[0]), 1);
    chk("short_white", int'(wc[0]), 4);
    chk("short_done_cnt", dc[0], 1);

    // Reset in the middle of a frame.
    reset_dut();
    step(mk(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    for (int k = 0; k < 2; k++) step(mk(1'b0, 1'b1, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200));
    reset_dut();
    frame4(8'd0, 8'd200);
    idle(2);
    chk("midrst_done_cnt", dc[0], 1);
    chk("midrst_white", int'(wc[0]), 4);
    chk("midrst_err", int'(fe[0]), 0);

    // Whole 768-wide frame of white, back to back.
    reset_dut();
    step(mk(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    for (int k = 0; k < 768 * 16 / 2; k++)
      step(mk(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255));
    idle(2);
    chk("full_done_cnt", dc[2], 1);
    chk("full_white", int'(wc[2]), 768 * 16);
    chk("full_err", int'(fe[2]), 0);
    chk("full_row", int'(ro[2]), 15);
    chk("full_col", int'(co[2]), 766);

    // Random traffic around the threshold with random frame starts.
    reset_dut();
    begin
      logic vs;
      vs = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 9) == 0) vs = ~vs;
        step(mk(vs, ($urandom_range(0, 3) != 0),
                8'($urandom_range(60, 120)), 8'($urandom_range(60, 120)), 8'($urandom_range(60, 120)),
                8'($urandom_range(60, 120)), 8'($urandom_range(60, 120)), 8'($urandom_range(60, 120))));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/threshold_stage.md
Name: threshold_stage

Overview:
- Sits directly downstream of the image reader.
- Consumes its even/odd RGB pixel-pair stream (pair valid = horizontal pulse, frame start = vertical pulse).
- Binarises each pixel against a brightness threshold and emits a black/white pixel-pair stream for the image writer.
- Tracks frame position and white-pixel count, and flags malformed frames.

Parameters:
- IMAGE_WIDTH, 768: pixels per row; even, >= 2.
- IMAGE_HEIGHT, 512: rows per frame.
- THRESHOLD, 90: per-pixel brightness threshold, 0..255.
- INVERT, 0: 1 swaps black and white in the output.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- vsync_in  input  1  vertical pulse from the reader; a rising edge marks a new frame.
- hsync_in  input  1  pair valid; high = one even/odd pixel pair on the data inputs this cycle.
- red_even_in, green_even_in, blue_even_in  input  8 each  even pixel.
- red_odd_in, green_odd_in, blue_odd_in  input  8 each  odd pixel.
- red_even_out, green_even_out, blue_even_out  output  8 each  binarised even pixel.
- red_odd_out, green_odd_out, blue_odd_out  output  8 each  binarised odd pixel.
- out_valid  output  1  output pair valid.
- vsync_out  output  1  vsync_in delayed 2 cycles.
- frame_done  output  1  one-cycle pulse coincident with the last pair of a frame.
- white_count  output  19  white pixels in the current/last frame.
- row_out  output  10  row index of the current output pair.
- col_out  output  11  column index of the even pixel of the current output pair.
- frame_error  output  1  sticky malformed-frame flag.

Behaviour:
- Reset (async, reset=0):
  - All outputs are 0.
  - Pipeline valids and the delayed vsync are 0.
  - Counters are 0; FSM is IDLE.
  - Reset mid-frame aborts the frame immediately; no frame_done.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 (cycle N+1): per lane, sum = R+G+B, zero-extended to 10 bits (max 765, no overflow). Register the sums, valid, and vsync.
  - Stage 2 (cycle N+2): white = (sum > 3*THRESHOLD) XOR INVERT, with 3*THRESHOLD a 10-bit constant. Strictly greater: sum == 3*THRESHOLD gives black.
  - White drives 8'hFF on R, G and B; black drives 8'h00.
  - Input pair at cycle N gives out_valid=1 at N+2.
  - Output data registers load only when the stage-1 valid is high; otherwise they hold their last value.
- Back-to-back valid input: one pair per cycle, no stalls, no backpressure.
- Frame bookkeeping runs on the output side, using vsync edge detection on the 2-cycle-delayed vsync. A vsync rise and a valid pair in the same input cycle: the pair belongs to the new frame.
- FSM states IDLE, ACTIVE, DONE:
  - On a delayed-vsync rising edge in any state: clear the pair counter, row, col and white_count, then go to ACTIVE.
  - If that edge occurs in ACTIVE with pair counter != 0, set frame_error (short frame).
  - ACTIVE, each output pair:
    - white_count += number of white pixels in the pair (0, 1 or 2).
    - col += 2; at col == IMAGE_WIDTH-2, col wraps to 0 and row += 1.
    - The pair counter increments.
    - row_out/col_out show the position of the pair being output, before the increment.
  - ACTIVE, pair counter == IMAGE_WIDTH*IMAGE_HEIGHT/2 - 1 on an output pair: frame_done=1 that cycle, go to DONE.
  - DONE: white_count, row and col hold until the next vsync rise.
- Pairs arriving in IDLE or DONE are still binarised and output (out_valid=1), but not counted; they set frame_error.
- frame_error clears only on reset.
- vsync_out tracks vsync_in with exactly 2 cycles of delay, independent of FSM state.

Test Plan:
- Reset, then vsync_in rise, then 4 valid pairs, with IMAGE_WIDTH=4, IMAGE_HEIGHT=2, THRESHOLD=90:
  - Even pixel (100,100,100), odd pixel (80,80,80).
  - Each out_valid occurs 2 cycles after its hsync_in.
  - Outputs: even = FF,FF,FF; odd = 00,00,00.
  - frame_done pulses on the 4th pair.
  - white_count=4; row_out/col_out sequence (0,0), (0,2), (1,0), (1,2).
- Boundary compare: sum exactly 270 (90,90,90) -> black; (91,90,90) -> white. With INVERT=1 both results flip.
- Full-size defaults, 196608 back-to-back pairs, all pixels at (255,255,255):
  - frame_done exactly once, on the last pair.
  - white_count=393216; no frame_error.
- Short frame: vsync rise after 2 of 4 pairs (small parameters) -> frame_error=1, counters restart, the next full frame completes normally, and frame_error stays 1.
- Extra pair after frame_done -> output still binarised, white_count unchanged, frame_error=1.
- Reset asserted mid-frame -> all outputs 0 immediately; after release and a new vsync, the next frame counts from 0 with correct frame_done.
